// File: rtl/mem_arbiter_if.sv
// Bundle of requester, RAM and status signals around mem_arbiter.
// slave = arbiter side; master = requesters plus RAM.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              m_req;
    logic              m_we;
    logic [1:0]        m_wwidth;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              halt;
    logic              i_ack;
    logic              m_ack;
    logic              d_ack;
    logic [DATA_W-1:0] rdata;
    logic              ram_cs;
    logic              ram_we;
    logic [1:0]        ram_wwidth;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    modport slave (
        input  i_req, i_addr, m_req, m_we, m_wwidth, m_addr, m_wdata,
               d_req, d_we, d_addr, d_wdata, halt, ram_rdata,
        output i_ack, m_ack, d_ack, rdata, ram_cs, ram_we, ram_wwidth,
               ram_addr, ram_wdata, busy
    );

    modport master (
        output i_req, i_addr, m_req, m_we, m_wwidth, m_addr, m_wdata,
               d_req, d_we, d_addr, d_wdata, halt, ram_rdata,
        input  i_ack, m_ack, d_ack, rdata, ram_cs, ram_we, ram_wwidth,
               ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shared single-port RAM arbiter: debug first, then data/ifetch round-robin; IDLE->ACCESS->COMPLETE.
// Define MEM_ARBITER_STATS_EN to add saturating grant and wait counters.
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0]  stat_i,
    output logic [31:0]  stat_m,
    output logic [31:0]  stat_d,
    output logic [31:0]  stat_wait
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_e;

    state_e            state_q;
    logic [2:0]        gnt_q;      // one-hot {d, m, i}
    logic              last_m_q;   // 1: data port won the last m/i grant
    logic              we_q;
    logic [1:0]        ww_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cs_q;
    logic              ram_we_q;
    logic [2:0]        ack_q;

    logic              i_elig;
    logic [2:0]        win_d;
    logic              cmd_we_d;
    logic [1:0]        cmd_ww_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_d;

    assign i_elig = bus.i_req & ~bus.halt;

    always_comb begin
        win_d = 3'b000;
        if (bus.d_req)                 win_d = 3'b100;
        else if (bus.m_req && i_elig)  win_d = last_m_q ? 3'b001 : 3'b010;
        else if (bus.m_req)            win_d = 3'b010;
        else if (i_elig)               win_d = 3'b001;
    end

    always_comb begin
        cmd_we_d    = 1'b0;
        cmd_ww_d    = 2'b11;
        cmd_addr_d  = bus.i_addr;
        cmd_wdata_d = '0;
        if (win_d[2]) begin
            cmd_we_d    = bus.d_we;
            cmd_addr_d  = bus.d_addr;
            cmd_wdata_d = bus.d_wdata;
        end else if (win_d[1]) begin
            cmd_we_d    = bus.m_we;
            cmd_ww_d    = bus.m_wwidth;
            cmd_addr_d  = bus.m_addr;
            cmd_wdata_d = bus.m_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            last_m_q <= 1'b1;
            we_q     <= 1'b0;
            ww_q     <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            cs_q     <= 1'b0;
            ram_we_q <= 1'b0;
            ack_q    <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|win_d) begin
                        state_q  <= ACCESS;
                        gnt_q    <= win_d;
                        we_q     <= cmd_we_d;
                        ww_q     <= cmd_ww_d;
                        addr_q   <= cmd_addr_d;
                        wdata_q  <= cmd_wdata_d;
                        cs_q     <= 1'b1;
                        ram_we_q <= cmd_we_d;
                        if (!win_d[2]) last_m_q <= win_d[1];
                    end
                end
                ACCESS: begin
                    state_q  <= COMPLETE;
                    cs_q     <= 1'b0;
                    ram_we_q <= 1'b0;
                    ack_q    <= gnt_q;
                end
                COMPLETE: begin
                    state_q <= IDLE;
                    ack_q   <= 3'b000;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM read data arrives in COMPLETE, so it is steered straight through.
    assign bus.rdata      = ((|ack_q) && !we_q) ? bus.ram_rdata : '0;
    assign bus.i_ack      = ack_q[0];
    assign bus.m_ack      = ack_q[1];
    assign bus.d_ack      = ack_q[2];
    assign bus.ram_cs     = cs_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wwidth = ww_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_wdata  = wdata_q;
    assign bus.busy       = (state_q != IDLE);

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] stat_i_q, stat_m_q, stat_d_q, stat_wait_q;
    logic        grant_ok;
    logic        waiting;

    assign grant_ok = (state_q == IDLE);
    assign waiting  = (bus.i_req & ~ack_q[0]) | (bus.m_req & ~ack_q[1]) |
                      (bus.d_req & ~ack_q[2]);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_i_q    <= '0;
            stat_m_q    <= '0;
            stat_d_q    <= '0;
            stat_wait_q <= '0;
        end else begin
            stat_i_q    <= sat_inc(stat_i_q, grant_ok & win_d[0]);
            stat_m_q    <= sat_inc(stat_m_q, grant_ok & win_d[1]);
            stat_d_q    <= sat_inc(stat_d_q, grant_ok & win_d[2]);
            stat_wait_q <= sat_inc(stat_wait_q, waiting);
        end
    end

    assign stat_i    = stat_i_q;
    assign stat_m    = stat_m_q;
    assign stat_d    = stat_d_q;
    assign stat_wait = stat_wait_q;
`endif
endmodule
